// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the MEM stage: EX/MEM and MEM/WB bundles,
// funct3 encodings for loads/stores and the MEM bus state encoding.
package pipeline_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  typedef struct packed {
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] PCPlus4;
    logic [4:0]  Rd;
    logic [31:0] ImmExt;
  } exmem_t;

  typedef struct packed {
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [31:0] ALUResult;
    logic [31:0] ReadData;
    logic [31:0] PCPlus4;
    logic [4:0]  Rd;
    logic [31:0] ImmExt;
  } memwb_t;

  typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the byte/half addressed by a from the bus word
// and sign- or zero-extends it according to funct3.
module mem_load_align
  import pipeline_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_a,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_read_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_a, 3'b000};

  always_comb begin
    o_read_data = i_rdata;
    case (i_funct3)
      F3_B:    o_read_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_read_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_read_data = {24'd0, w_shifted[7:0]};
      F3_HU:   o_read_data = {16'd0, w_shifted[15:0]};
      default: o_read_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage driving a req/gnt + rvalid data bus, stalling while an
// access is outstanding. Optional alignment trap: DRAGON_MEM_MISALIGN_CHECK_EN.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  exmem_t      inputs,
  output memwb_t      outputs,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic [31:0] ALUResultM,
  output logic [4:0]  RdM,
  output logic        RegWriteM,
  output logic        bus_timeout,
  output mem_state_t  dbg_state
`ifdef DRAGON_MEM_MISALIGN_CHECK_EN
  ,
  output logic        misaligned
`endif
);

  localparam bit               LP_TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] LP_TMO_LAST = CNT_W'(LP_TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  mem_state_t       r_state;
  mem_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_a;
  logic             w_load;
  logic             w_store;
  logic             w_mem_op;
  logic             w_req;
  logic             w_complete;
  logic             w_abort;
  logic             w_drop_wb;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_read_data;

  assign w_a     = inputs.ALUResult[1:0];
  assign w_load  = (inputs.ResultSrc == RESULTSRC_LOAD);
  assign w_store = inputs.MemWrite;

`ifdef DRAGON_MEM_MISALIGN_CHECK_EN
  logic w_misalign;

  always_comb begin
    w_misalign = 1'b0;
    case (inputs.funct3)
      F3_H, F3_HU: w_misalign = w_a[0];
      F3_W:        w_misalign = (w_a != 2'b00);
      default:     w_misalign = 1'b0;
    endcase
    w_misalign = w_misalign & (w_load | w_store);
  end

  // A trapped access never leaves IDLE, so the pulse lasts exactly one cycle.
  assign misaligned = w_misalign & ~reset;
  assign w_mem_op   = (w_load | w_store) & ~w_misalign;
  assign w_drop_wb  = w_abort | w_misalign;
`else
  assign w_mem_op   = w_load | w_store;
  assign w_drop_wb  = w_abort;
`endif

  assign w_complete = (r_state == RESP) & dmem_rvalid;
  // Completion in the last allowed cycle wins over the timeout.
  assign w_abort    = LP_TMO_EN & (r_state != IDLE) & (r_cnt == LP_TMO_LAST)
                    & ~w_complete & ~reset;

  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          w_req  = 1'b1;
          w_next = dmem_gnt ? RESP : REQ;
        end
      end
      REQ: begin
        w_req = 1'b1;
        if (dmem_gnt) w_next = RESP;
      end
      RESP: begin
        if (dmem_rvalid) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) r_cnt <= '0;
      else                 r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = inputs.WriteData;
    if (w_store) begin
      case (inputs.funct3)
        F3_B: begin
          w_be    = 4'b0001 << w_a;
          w_wdata = {4{inputs.WriteData[7:0]}};
        end
        F3_H: begin
          w_be    = 4'b0011 << {w_a[1], 1'b0};
          w_wdata = {2{inputs.WriteData[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = inputs.WriteData;
        end
      endcase
    end
  end

  mem_load_align u_align (
    .i_funct3    (inputs.funct3),
    .i_a         (w_a),
    .i_rdata     (dmem_rdata),
    .o_read_data (w_read_data)
  );

  assign dmem_req    = w_req & ~reset;
  assign dmem_we     = w_store;
  assign dmem_addr   = {inputs.ALUResult[31:2], 2'b00};
  assign dmem_be     = w_be;
  assign dmem_wdata  = w_wdata;
  assign StallM      = w_mem_op & ~w_complete & ~w_abort & ~reset;
  assign bus_timeout = w_abort;
  assign ALUResultM  = inputs.ALUResult;
  assign RdM         = inputs.Rd;
  assign RegWriteM   = inputs.RegWrite;
  assign dbg_state   = r_state;

  always_comb begin
    outputs           = '0;
    outputs.RegWrite  = inputs.RegWrite & ~w_drop_wb;
    outputs.ResultSrc = inputs.ResultSrc;
    outputs.ALUResult = inputs.ALUResult;
    outputs.ReadData  = w_read_data;
    outputs.PCPlus4   = inputs.PCPlus4;
    outputs.Rd        = inputs.Rd;
    outputs.ImmExt    = inputs.ImmExt;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: per-access cycle plans (grant/response
// delays) drive a bus responder; a compare process checks every cycle.
module tb_mem_stage;
  import pipeline_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  exmem_t      in_r;
  memwb_t      out_w;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_m, reg_write_m, bus_timeout;
  logic [31:0] alu_result_m;
  logic [4:0]  rd_m;
  mem_state_t  dbg_state;
`ifdef DRAGON_MEM_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  int checks   = 0;
  int failures = 0;

  // expectations for the current cycle, set by the driver
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, chk_req, exp_tmo, exp_regwrite, chk_rd, exp_we;
  logic [31:0] exp_rd, exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic        exp_is_store;

  mem_stage #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .inputs      (in_r),
    .outputs     (out_w),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .StallM      (stall_m),
    .ALUResultM  (alu_result_m),
    .RdM         (rd_m),
    .RegWriteM   (reg_write_m),
    .bus_timeout (bus_timeout),
    .dbg_state   (dbg_state)
`ifdef DRAGON_MEM_MISALIGN_CHECK_EN
    ,
    .misaligned  (misaligned)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference model: spec-level load extraction and store lane building
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*a +: 8];
    h = (a == 2'd3) ? {8'h00, rd[31:24]} : rd[8*a +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic st, input logic [2:0] f3, input logic [1:0] a);
    int v;
    if (!st) return 4'hF;
    case (f3)
      3'b000:  v = 1 << a;
      3'b001:  v = 3 << (a & 2'b10);
      default: v = 15;
    endcase
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      3'b001:  return {wd[15:0], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  function automatic exmem_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                                input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] wd);
    exmem_t e;
    e.RegWrite  = rw;
    e.ResultSrc = rs;
    e.MemWrite  = mw;
    e.funct3    = f3;
    e.ALUResult = alu;
    e.WriteData = wd;
    e.PCPlus4   = $urandom;
    e.Rd        = 5'($urandom_range(0, 31));
    e.ImmExt    = $urandom;
    return e;
  endfunction

  // scoreboard compare: every cycle the bench has set an expectation
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall_m), 32'(exp_stall));
      chk("bus_timeout", 32'(bus_timeout), 32'(exp_tmo));
      if (chk_req) chk("dmem_req", 32'(dmem_req), 32'(exp_req));
      if (exp_req && chk_req) begin
        chk("dmem_addr", dmem_addr, exp_addr);
        chk("dmem_we", 32'(dmem_we), 32'(exp_we));
        chk("dmem_be", 32'(dmem_be), 32'(exp_be));
        if (exp_is_store) chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
      if (chk_rd) chk("ReadData", out_w.ReadData, exp_rd);
      chk("wb_regwrite", 32'(out_w.RegWrite), 32'(exp_regwrite));
      chk("wb_alu", out_w.ALUResult, in_r.ALUResult);
      chk("wb_pc4", out_w.PCPlus4, in_r.PCPlus4);
      chk("wb_rd", 32'(out_w.Rd), 32'(in_r.Rd));
      chk("wb_imm", out_w.ImmExt, in_r.ImmExt);
      chk("wb_rsrc", 32'(out_w.ResultSrc), 32'(in_r.ResultSrc));
      chk("fwd_alu", alu_result_m, in_r.ALUResult);
      chk("fwd_rd", 32'(rd_m), 32'(in_r.Rd));
      chk("fwd_rw", 32'(reg_write_m), 32'(in_r.RegWrite));
    end
  end

  // driver: one instruction, grant after d cycles, response r cycles later
  task automatic do_access(input exmem_t ins, input int d, input int r,
                           input logic [31:0] rdata, input bit stray, output bit aborted);
    bit is_mem, is_load, will_abort;
    int c, last;
    is_load    = (ins.ResultSrc == 2'b01);
    is_mem     = is_load || ins.MemWrite;
    c          = d + r;
    will_abort = is_mem && (c > T);
    last       = !is_mem ? 0 : (will_abort ? T : c);
    aborted    = will_abort;
    in_r       = ins;
    exp_addr     = {ins.ALUResult[31:2], 2'b00};
    exp_we       = ins.MemWrite;
    exp_is_store = ins.MemWrite;
    exp_be       = m_be(ins.MemWrite, ins.funct3, ins.ALUResult[1:0]);
    exp_wdata    = m_wdata(ins.funct3, ins.WriteData);
    exp_rd       = m_load(ins.funct3, ins.ALUResult[1:0], rdata);
    for (int k = 0; k <= last; k++) begin
      dmem_gnt     = is_mem && (k == d);
      dmem_rvalid  = (is_mem && (k == c)) || (stray && !is_mem);
      dmem_rdata   = (k == c) ? rdata : $urandom;
      exp_stall    = is_mem && (k != last);
      exp_req      = is_mem && (k <= d);
      chk_req      = !(will_abort && (k == last));
      exp_tmo      = will_abort && (k == last);
      exp_regwrite = ins.RegWrite && !(will_abort && (k == last));
      chk_rd       = is_load && !will_abort && (k == last);
      chk_en       = 1'b1;
      @(posedge clk); #1;
    end
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  exmem_t alu_op;
  bit     ab;

  initial begin
    reset       = 1'b1;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    in_r        = mk(1'b1, 2'b01, 1'b0, F3_W, 32'h1000_0000, 32'h0);

    // pin the model with hand-computed values
    chk("pin_lb",   m_load(3'b000, 2'd3, 32'h8011_2233), 32'hFFFF_FF80);
    chk("pin_lbu",  m_load(3'b100, 2'd3, 32'h8011_2233), 32'h0000_0080);
    chk("pin_lh",   m_load(3'b001, 2'd2, 32'h8011_2233), 32'hFFFF_8011);
    chk("pin_be",   32'(m_be(1'b1, 3'b001, 2'd2)), 32'h0000_000C);
    chk("pin_wd",   m_wdata(3'b001, 32'h0000_ABCD), 32'hABCD_ABCD);

    // reset holds bus/stall low even with a load presented
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall_m), 32'h0);
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_tmo", 32'(bus_timeout), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // directed accesses
    do_access(mk(1'b1, 2'b01, 1'b0, F3_W, 32'h1000_0008, 32'h0), 0, 1, 32'hDEAD_BEEF, 1'b0, ab);
    do_access(mk(1'b1, 2'b01, 1'b0, F3_B, 32'h1000_0003, 32'h0), 0, 1, 32'h8011_2233, 1'b0, ab);
    do_access(mk(1'b1, 2'b01, 1'b0, F3_BU, 32'h1000_0003, 32'h0), 1, 2, 32'h8011_2233, 1'b0, ab);
    do_access(mk(1'b0, 2'b00, 1'b1, F3_H, 32'h1000_0002, 32'h0000_ABCD), 3, 1, 32'h0, 1'b0, ab);
    // grant never comes: timeout, then a late rvalid in IDLE is ignored
    do_access(mk(1'b1, 2'b01, 1'b0, F3_W, 32'h1000_0010, 32'h0), 99, 1, 32'h0, 1'b0, ab);
    chk("tmo_seen", 32'(ab), 32'h1);
    alu_op = mk(1'b1, 2'b00, 1'b0, 3'b000, $urandom, $urandom);
    do_access(alu_op, 0, 1, 32'h0, 1'b1, ab);

    // reset while waiting for the response
    in_r         = mk(1'b1, 2'b01, 1'b0, F3_W, 32'h2000_0004, 32'h0);
    exp_addr     = 32'h2000_0004;
    exp_we       = 1'b0;
    exp_is_store = 1'b0;
    exp_be       = 4'hF;
    dmem_gnt = 1'b1; exp_stall = 1'b1; exp_req = 1'b1; chk_req = 1'b1;
    exp_tmo = 1'b0; exp_regwrite = 1'b1; chk_rd = 1'b0; chk_en = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0; reset = 1'b1; exp_stall = 1'b0; exp_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_resp_state", 32'(dbg_state), 32'(IDLE));
    alu_op = mk(1'b1, 2'b10, 1'b0, 3'b000, $urandom, $urandom);
    do_access(alu_op, 0, 1, 32'h0, 1'b1, ab);

    // randomized mix of loads, stores and ALU ops
    for (int n = 0; n < 300; n++) begin
      exmem_t e;
      int kind, d, r;
      logic [31:0] addr;
      kind = $urandom_range(0, 2);
      addr = $urandom;
      d    = ($urandom_range(0, 7) == 0) ? 50 : $urandom_range(0, 3);
      r    = $urandom_range(1, 3);
      if (kind == 0) begin
        e = mk(1'($urandom), 2'b01, 1'b0, 3'($urandom_range(0, 7)), addr, $urandom);
      end else if (kind == 1) begin
        logic [2:0] f3;
        f3 = 3'($urandom_range(0, 2));
        if (f3 == F3_H) addr[0] = 1'b0;
        e = mk(1'($urandom), 2'b00, 1'b1, f3, addr, $urandom);
      end else begin
        logic [1:0] rs;
        rs = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
        e = mk(1'($urandom), rs, 1'b0, 3'($urandom_range(0, 7)), addr, $urandom);
      end
      do_access(e, d, r, $urandom, 1'b0, ab);
      if (ab) begin
        alu_op = mk(1'b1, 2'b00, 1'b0, 3'b000, $urandom, $urandom);
        do_access(alu_op, 0, 1, 32'h0, 1'b1, ab);
      end
    end

    chk_en = 1'b0;
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage; consumes the exmem_t bundle written by the execute stage and produces memwb_t for writeback.
- Drives a split request/response data-memory bus: the request phase uses req/gnt, the response phase uses rvalid.
- Builds byte enables and store-data lane replication, and sign- or zero-extends load data.
- Stalls the pipeline while an access is outstanding and feeds forwarding/hazard information (ALUResultM, RdM, RegWriteM) back toward execute and the hazard unit.

Parameters:
- TIMEOUT_CYCLES, default 0: cycles an access may wait, in REQ or RESP combined, before it is aborted. 0 disables the timeout.
- CNT_W, default 8: width of the timeout counter. Required: TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inputs  in  exmem_t  fields RegWrite, ResultSrc[1:0], MemWrite, funct3[2:0], ALUResult[31:0], WriteData[31:0], PCPlus4, Rd[4:0], ImmExt
- outputs  out  memwb_t  fields RegWrite, ResultSrc, ALUResult, ReadData[31:0], PCPlus4, Rd, ImmExt
- dmem_req  out  1  request valid
- dmem_we  out  1  write
- dmem_addr  out  32  word address, {ALUResult[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  response valid; exactly one per granted request
- dmem_rdata  in  32  read data, valid with rvalid
- StallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
- ALUResultM  out  32  forwarding value
- RdM  out  5  to hazard unit
- RegWriteM  out  1  to hazard unit
- bus_timeout  out  1  one-cycle abort pulse

Behaviour:
- Access classification:
  - load = ResultSrc==2'b01.
  - store = MemWrite.
  - mem_op = load|store. Load and store are never both set.
- State machine: IDLE, REQ, RESP.
  - IDLE: on mem_op, dmem_req=1 combinationally.
    - gnt=1 that cycle → RESP.
    - gnt=0 → REQ.
  - REQ: hold dmem_req=1 with stable addr/be/wdata/we. gnt → RESP.
  - RESP: dmem_req=0. rvalid → IDLE; this is the completion cycle.
- Stall and completion:
  - StallM = mem_op & !(state==RESP & rvalid) & !abort.
  - Minimum access latency is 2 cycles: the grant cycle, then the response cycle.
  - The EX/MEM register is frozen while stalled, so the inputs stay stable.
- Byte enables and store data, with a = ALUResult[1:0]:
  - SB (funct3 000): be = 4'b0001<<a; wdata = {4{WriteData[7:0]}}.
  - SH (funct3 001): be = 4'b0011<<{a[1],1'b0}; wdata = {2{WriteData[15:0]}}.
  - SW and all other funct3: be = 4'b1111; wdata = WriteData.
  - Loads assert be = 4'b1111 and we=0.
- Load data:
  - The byte or half is selected by a from dmem_rdata in the completion cycle.
  - LB/LH (000/001) sign-extend; LBU/LHU (100/101) zero-extend; LW (010) passes through.
  - Funct3 011, 110 and 111 are treated as LW.
  - ReadData is combinational, valid only in the completion cycle; MEM/WB captures it when StallM=0.
- Pass-through outputs:
  - outputs RegWrite, ResultSrc, ALUResult, PCPlus4, Rd, ImmExt = inputs.
  - ALUResultM = inputs.ALUResult; RdM = inputs.Rd; RegWriteM = inputs.RegWrite.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter clears in IDLE and increments each cycle in REQ/RESP.
  - When count==TIMEOUT_CYCLES-1 and the access has not completed, abort=1 that cycle:
    - bus_timeout=1;
    - state → IDLE;
    - outputs.RegWrite forced 0;
    - StallM=0.
  - A late rvalid arriving in IDLE is ignored.
  - Completion and timeout in the same cycle: completion wins, no abort.
- Reset:
  - state=IDLE, counter=0.
  - dmem_req, StallM and bus_timeout are forced 0 during any cycle with reset high, including mid-REQ or mid-RESP.
  - An outstanding response after reset is ignored.
- Non-memory instructions: state stays IDLE, StallM=0, zero added latency.

Optional Feature:
- Macro: DRAGON_MEM_MISALIGN_CHECK_EN.
- Defined:
  - Misalignment = (SH/LH/LHU with a[0]) or (SW/LW with a!=0).
  - On misalignment the stage issues no request, forces outputs.RegWrite=0 and StallM=0.
  - Adds a port misaligned (out, 1) that pulses one cycle.
- Undefined:
  - No check; the access proceeds.
  - Enables shift by a and truncate to 4 bits.
  - Load extraction uses the same shift.
  - No misaligned port.

Decomposition:
- pipeline_pkg:
  - memwb_t;
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - RESULTSRC_LOAD=2'b01;
  - enum mem_state_t {IDLE, REQ, RESP}.
- Sub-module mem_load_align (combinational): funct3, a, rdata → ReadData.
- Byte-enable and store-data generation stay in mem_stage.

Test Plan:
- LW, addr 0x1000_0008: gnt same cycle, rvalid next, rdata 0xDEADBEEF → StallM=1 for 1 cycle; ReadData=0xDEADBEEF; be=4'b1111.
- LB, addr 0x...03: rdata 0x80112233 → ReadData=0xFFFFFF80. LBU at same address → 0x00000080.
- SH, addr 0x...02, WriteData 0x0000ABCD: gnt delayed 3 cycles → be=4'b1100, wdata=0xABCDABCD, we=1; req stable across the wait; StallM lasts 4 cycles.
- TIMEOUT_CYCLES=4, LW, gnt never → bus_timeout pulses in the 4th cycle; RegWrite to WB=0; StallM drops; a later rvalid is ignored.
- Reset asserted in RESP → next cycle state IDLE, dmem_req=0, StallM=0; an ADD in EX/MEM passes with StallM=0.
- With DRAGON_MEM_MISALIGN_CHECK_EN, LW at 0x...01 → no dmem_req, misaligned=1 for one cycle, RegWrite suppressed.
